// File: rtl/dap_rx_pkt_dispatcher.sv
// rtl/dap_rx_pkt_dispatcher.sv - rebuilds CMSIS-DAP OUT packet boundaries and dispatches packets to the command engines
// Optional feature macro: DAP_RX_ABORT_EN (early DAP_TransferAbort detection at USB reception time)
module dap_rx_pkt_dispatcher #(
    parameter logic [3:0] P_ENDPOINT  = 4'd2,
    parameter int         P_LEN_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] usb_endpt,
    input  logic       usb_rxact,
    input  logic       usb_rxval,
    input  logic       usb_rxpktval,
    input  logic [7:0] usb_rxdat,
    output logic       len_full,
    output logic       len_overflow,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m0_axis_tdata,
    output logic       m0_axis_tvalid,
    output logic       m0_axis_tlast,
    input  logic       m0_axis_tready,
    output logic [7:0] m1_axis_tdata,
    output logic       m1_axis_tvalid,
    output logic       m1_axis_tlast,
    input  logic       m1_axis_tready,
    output logic       transfer_abort
);

    localparam int AW = (P_LEN_DEPTH > 1) ? $clog2(P_LEN_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(P_LEN_DEPTH);

    typedef enum logic {IDLE = 1'b0, FWD = 1'b1} state_t;

    // ---------------------------------------------------------------
    // Length monitor: counts bytes of the tracked endpoint on the USB bus
    // ---------------------------------------------------------------
    logic       sel;
    logic       act_q;
    logic       act_rise;
    logic [9:0] rx_cnt;
    logic       push_req;

    assign sel      = (usb_endpt == P_ENDPOINT);
    assign act_rise = usb_rxact & sel & ~act_q;
    // A commit carries only the bytes counted before it; empty packets are never queued.
    assign push_req = usb_rxpktval & sel & (rx_cnt != 10'd0);

    // Track the receive-active level so a new packet can be recognised by its rising edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_q <= 1'b0;
        end else begin
            act_q <= usb_rxact & sel;
        end
    end

    // Per-packet byte counter, cleared at packet start and saturating at its maximum.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cnt <= 10'd0;
        end else if (act_rise) begin
            rx_cnt <= (usb_rxval & sel) ? 10'd1 : 10'd0;
        end else if (usb_rxval && sel && rx_cnt != 10'h3FF) begin
            rx_cnt <= rx_cnt + 10'd1;
        end
    end

    // ---------------------------------------------------------------
    // Packet-length FIFO
    // ---------------------------------------------------------------
    logic [9:0]  len_mem [P_LEN_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          pop;
    logic          push_ok;
    state_t        state;
    state_t        state_nxt;

    assign empty    = (count == '0);
    assign len_full = (count == FULL_CNT);
    assign pop      = (state == IDLE) & ~empty & s_axis_tvalid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req & (~len_full | pop);

    // Length storage; contents need no reset because occupancy governs validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            len_mem[wr_ptr] <= rx_cnt;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            len_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                len_overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Dispatcher FSM
    // ---------------------------------------------------------------
    logic [9:0] rem;
    logic       port;
    logic       hs;

    assign hs = s_axis_tvalid & s_axis_tready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start a packet when a length and its command byte are both present.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = FWD;
            FWD:     if (hs && rem == 10'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Packet context: remaining byte count and target port, latched from the peeked command byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem  <= 10'd0;
            port <= 1'b0;
        end else if (pop) begin
            rem  <= len_mem[rd_ptr];
            port <= (s_axis_tdata == 8'h05) || (s_axis_tdata == 8'h06);
        end else if (state == FWD && hs) begin
            rem  <= rem - 10'd1;
        end
    end

    // Outputs: zero-latency pass-through to the selected engine while forwarding.
    always_comb begin
        s_axis_tready  = 1'b0;
        m0_axis_tdata  = 8'h00;
        m0_axis_tvalid = 1'b0;
        m0_axis_tlast  = 1'b0;
        m1_axis_tdata  = 8'h00;
        m1_axis_tvalid = 1'b0;
        m1_axis_tlast  = 1'b0;
        if (state == FWD) begin
            if (port) begin
                m1_axis_tdata  = s_axis_tdata;
                m1_axis_tvalid = s_axis_tvalid;
                m1_axis_tlast  = (rem == 10'd1);
                s_axis_tready  = m1_axis_tready;
            end else begin
                m0_axis_tdata  = s_axis_tdata;
                m0_axis_tvalid = s_axis_tvalid;
                m0_axis_tlast  = (rem == 10'd1);
                s_axis_tready  = m0_axis_tready;
            end
        end
    end

    // ---------------------------------------------------------------
    // Early abort detection
    // ---------------------------------------------------------------
`ifdef DAP_RX_ABORT_EN
    logic first_byte;

    assign first_byte = usb_rxval & sel & (act_rise | (rx_cnt == 10'd0));

    // Pulse on the cycle after a packet's first byte turns out to be DAP_TransferAbort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            transfer_abort <= 1'b0;
        end else begin
            transfer_abort <= first_byte && (usb_rxdat == 8'h07);
        end
    end
`else
    logic unused_rxdat;

    assign unused_rxdat   = ^usb_rxdat;
    assign transfer_abort = 1'b0;
`endif

endmodule

// File: tb/tb_dap_rx_pkt_dispatcher.sv
// tb/tb_dap_rx_pkt_dispatcher.sv - self-checking bench for dap_rx_pkt_dispatcher
module tb_dap_rx_pkt_dispatcher;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] usb_endpt;
    logic       usb_rxact, usb_rxval, usb_rxpktval;
    logic [7:0] usb_rxdat;
    logic       len_full, len_overflow;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic [7:0] m0_axis_tdata, m1_axis_tdata;
    logic       m0_axis_tvalid, m0_axis_tlast, m0_axis_tready;
    logic       m1_axis_tvalid, m1_axis_tlast, m1_axis_tready;
    logic       transfer_abort;

    always #5 clk = ~clk;

    dap_rx_pkt_dispatcher #(.P_ENDPOINT(4'd2), .P_LEN_DEPTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .usb_endpt(usb_endpt), .usb_rxact(usb_rxact), .usb_rxval(usb_rxval),
        .usb_rxpktval(usb_rxpktval), .usb_rxdat(usb_rxdat),
        .len_full(len_full), .len_overflow(len_overflow),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid),
        .m0_axis_tlast(m0_axis_tlast), .m0_axis_tready(m0_axis_tready),
        .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid),
        .m1_axis_tlast(m1_axis_tlast), .m1_axis_tready(m1_axis_tready),
        .transfer_abort(transfer_abort)
    );

    typedef struct {
        int          len;
        logic [63:0] bytes;
        logic        port;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [9:0]  sb[$];
    logic [7:0]  src_q[$];
    logic [7:0]  pb [16];
    logic        src_en = 1'b0;
    logic        tog0 = 1'b0;
    logic        m1_stall = 1'b0;
    int          cyc = 0;
    int          last_tlast_cyc = -100;
    int          last_gap = 0;
    logic        any_valid_q = 1'b0;
    logic        abort_seen = 1'b0;
    int          beats0 = 0;
    int          beats1 = 0;
    logic [9:0]  e_beat;
    logic        hs0, hs1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Receive-FIFO model and sink readiness, updated just after each clock edge.
    always @(posedge clk) begin
        #2;
        s_axis_tvalid  = src_en && (src_q.size() > 0);
        s_axis_tdata   = (src_q.size() > 0) ? src_q[0] : 8'h00;
        m0_axis_tready = tog0 ? ~m0_axis_tready : 1'b1;
        m1_axis_tready = ~m1_stall;
    end

    // Output monitor and scoreboard check, sampled at the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (transfer_abort) abort_seen = 1'b1;
            if (m0_axis_tvalid || m1_axis_tvalid) begin
                chk("single_port_valid", {31'b0, m0_axis_tvalid & m1_axis_tvalid}, 32'd0);
                if (!any_valid_q) last_gap = cyc - last_tlast_cyc;
            end
            any_valid_q = m0_axis_tvalid | m1_axis_tvalid;
            hs0 = m0_axis_tvalid & m0_axis_tready;
            hs1 = m1_axis_tvalid & m1_axis_tready;
            if (s_axis_tvalid && s_axis_tready) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                chk("fwd_handshake", {31'b0, hs0 | hs1}, 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e_beat = sb.pop_front();
                    chk("beat_port", {31'b0, hs1}, {31'b0, e_beat[9]});
                    chk("beat_data", {24'b0, hs1 ? m1_axis_tdata : m0_axis_tdata}, {24'b0, e_beat[7:0]});
                    chk("beat_last", {31'b0, hs1 ? m1_axis_tlast : m0_axis_tlast}, {31'b0, e_beat[8]});
                end
                if (hs0) beats0++;
                if (hs1) beats1++;
                if ((hs0 && m0_axis_tlast) || (hs1 && m1_axis_tlast)) last_tlast_cyc = cyc;
            end
        end
    end

    // Send one USB packet of n bytes from pb; committed packets on the tracked endpoint
    // that the receive FIFO accepts also enter the byte stream and the scoreboard.
    task automatic send_pkt(input int n, input logic [3:0] ep, input logic commit,
                            input logic to_fifo, input logic port);
        @(posedge clk); #1;
        usb_endpt = ep;
        usb_rxact = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            usb_rxval = 1'b1;
            usb_rxdat = pb[i];
        end
        @(posedge clk); #1;
        usb_rxval    = 1'b0;
        usb_rxpktval = commit;
        if (commit && to_fifo) begin
            for (int i = 0; i < n; i++) begin
                src_q.push_back(pb[i]);
                sb.push_back({port, (i == n - 1), pb[i]});
            end
        end
        @(posedge clk); #1;
        usb_rxpktval = 1'b0;
        usb_rxact    = 1'b0;
        usb_endpt    = 4'd0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        chk({name, "_drained"}, sb.size(), 32'd0);
    endtask

    initial begin
        vec_t vt [6];
        int   b0, b1;

        vt[0] = '{1, 64'h05,               1'b1};
        vt[1] = '{2, 64'h7F04,             1'b0};
        vt[2] = '{4, 64'h332211_07,        1'b0};
        vt[3] = '{3, 64'h0605FF,           1'b0};
        vt[4] = '{8, 64'h8877665544332206, 1'b1};
        vt[5] = '{2, 64'h0605,             1'b1};

        resetn = 1'b0;
        usb_endpt = 4'd0; usb_rxact = 1'b0; usb_rxval = 1'b0;
        usb_rxpktval = 1'b0; usb_rxdat = 8'h00;
        s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0;
        m0_axis_tready = 1'b1; m1_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m0_tvalid", {31'b0, m0_axis_tvalid}, 32'd0);
        chk("rst_m1_tvalid", {31'b0, m1_axis_tvalid}, 32'd0);
        chk("rst_m0_tlast", {31'b0, m0_axis_tlast}, 32'd0);
        chk("rst_m1_tlast", {31'b0, m1_axis_tlast}, 32'd0);
        chk("rst_m0_tdata", {24'b0, m0_axis_tdata}, 32'd0);
        chk("rst_m1_tdata", {24'b0, m1_axis_tdata}, 32'd0);
        chk("rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
        chk("rst_len_full", {31'b0, len_full}, 32'd0);
        chk("rst_len_overflow", {31'b0, len_overflow}, 32'd0);
        chk("rst_transfer_abort", {31'b0, transfer_abort}, 32'd0);
        resetn = 1'b1;
        src_en = 1'b1;

        // 3-byte general command packet
        b0 = beats0; b1 = beats1;
        pb[0] = 8'h00; pb[1] = 8'h01; pb[2] = 8'h02;
        send_pkt(3, 4'd2, 1'b1, 1'b1, 1'b0);
        wait_drain("t1");
        chk("t1_m0_beats", beats0 - b0, 32'd3);
        chk("t1_m1_beats", beats1 - b1, 32'd0);

        // DAP_TransferBlock packet goes to the transfer engine
        b0 = beats0; b1 = beats1;
        pb[0] = 8'h06; pb[1] = 8'hAA; pb[2] = 8'hBB; pb[3] = 8'hCC; pb[4] = 8'hDD;
        send_pkt(5, 4'd2, 1'b1, 1'b1, 1'b1);
        wait_drain("t2");
        chk("t2_m1_beats", beats1 - b1, 32'd5);
        chk("t2_m0_beats", beats0 - b0, 32'd0);

        // Table of packets with varied command bytes and lengths
        abort_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8; i++) pb[i] = vt[k].bytes[8*i +: 8];
            send_pkt(vt[k].len, 4'd2, 1'b1, 1'b1, vt[k].port);
        end
        wait_drain("table");
`ifndef DAP_RX_ABORT_EN
        chk("no_abort_when_disabled", {31'b0, abort_seen}, 32'd0);
`endif

        // Back-to-back packets with m0 ready toggling
        src_en = 1'b0;
        b0 = beats0;
        pb[0] = 8'h01; pb[1] = 8'h02;
        send_pkt(2, 4'd2, 1'b1, 1'b1, 1'b0);
        pb[0] = 8'h03; pb[1] = 8'h04; pb[2] = 8'h05; pb[3] = 8'h06;
        send_pkt(4, 4'd2, 1'b1, 1'b1, 1'b0);
        tog0 = 1'b1;
        @(posedge clk); #1;
        src_en = 1'b1;
        wait_drain("b2b");
        tog0 = 1'b0;
        chk("b2b_beats", beats0 - b0, 32'd6);
        chk("b2b_idle_gap", last_gap, 32'd2);

        // Uncommitted, zero-length and foreign-endpoint packets queue nothing
        b0 = beats0;
        pb[0] = 8'h0B; pb[1] = 8'h0C; pb[2] = 8'h0D;
        send_pkt(3, 4'd2, 1'b0, 1'b0, 1'b0);
        send_pkt(0, 4'd2, 1'b1, 1'b1, 1'b0);
        send_pkt(3, 4'd1, 1'b1, 1'b0, 1'b0);
        pb[0] = 8'h09; pb[1] = 8'h08;
        send_pkt(2, 4'd2, 1'b1, 1'b1, 1'b0);
        wait_drain("abandoned");
        chk("abandoned_beats", beats0 - b0, 32'd2);

        // Fill the length FIFO without draining, then overflow it
        src_en = 1'b0;
        b0 = beats0;
        for (int k = 1; k <= 9; k++) begin
            for (int i = 0; i < k; i++) pb[i] = 8'((k << 4) + i);
            send_pkt(k, 4'd2, 1'b1, k <= 8, 1'b0);
            chk($sformatf("len_full_after_%0d", k), {31'b0, len_full}, {31'b0, k >= 8});
            chk($sformatf("len_overflow_after_%0d", k), {31'b0, len_overflow}, {31'b0, k == 9});
        end
        src_en = 1'b1;
        wait_drain("ovf");
        chk("ovf_beats", beats0 - b0, 32'd36);
        chk("ovf_len_full_cleared", {31'b0, len_full}, 32'd0);
        chk("ovf_sticky", {31'b0, len_overflow}, 32'd1);

`ifdef DAP_RX_ABORT_EN
        // Abort byte seen on USB while the transfer engine is stalled mid-packet
        m1_stall = 1'b1;
        pb[0] = 8'h06; pb[1] = 8'h11; pb[2] = 8'h22;
        send_pkt(3, 4'd2, 1'b1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        usb_endpt = 4'd2; usb_rxact = 1'b1;
        @(posedge clk); #1;
        usb_rxval = 1'b1; usb_rxdat = 8'h07;
        @(posedge clk); #1;
        chk("abort_pulse", {31'b0, transfer_abort}, 32'd1);
        usb_rxval = 1'b0; usb_rxpktval = 1'b1;
        src_q.push_back(8'h07);
        sb.push_back({1'b0, 1'b1, 8'h07});
        @(posedge clk); #1;
        chk("abort_one_cycle", {31'b0, transfer_abort}, 32'd0);
        usb_rxpktval = 1'b0; usb_rxact = 1'b0; usb_endpt = 4'd0;
        m1_stall = 1'b0;
        wait_drain("abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dap_rx_pkt_dispatcher.md
# dap_rx_pkt_dispatcher

Sequences the CMSIS-DAP OUT byte stream leaving the endpoint receive FIFO and hands each USB packet to the correct command engine. It rebuilds USB packet boundaries the byte FIFO discards, classifies each packet by its first (command) byte, and forwards it with `tlast` to either the transfer engine or the general command engine. It sits between the DAP receive FIFO AXIS output and the DAP command executors, snooping the same USB receive bus as the FIFO.

## Interface
- `P_ENDPOINT`, 4'd2: OUT endpoint number tracked.
- `P_LEN_DEPTH`, 8: packet-length FIFO depth; power of two, 2..16.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `usb_endpt`  in  4  current USB endpoint.
- `usb_rxact`, `usb_rxval`, `usb_rxpktval`  in  1 each  USB receive active, byte valid, packet committed.
- `usb_rxdat`  in  8  USB receive byte.
- `len_full`  out  1  length FIFO full; system ANDs `!len_full` into `usb_rxrdy`.
- `len_overflow`  out  1  sticky: a commit arrived while full.
- `s_axis_tdata`  in  8 / `s_axis_tvalid`  in  1 / `s_axis_tready`  out  1  byte stream from receive FIFO.
- `m0_axis_tdata` 8, `m0_axis_tvalid` 1, `m0_axis_tlast` 1  out; `m0_axis_tready`  in  1  general command engine.
- `m1_axis_tdata` 8, `m1_axis_tvalid` 1, `m1_axis_tlast` 1  out; `m1_axis_tready`  in  1  transfer engine.
- `transfer_abort`  out  1  one-cycle abort pulse (see Configuration).

## Operation
- Length monitor: `sel = (usb_endpt == P_ENDPOINT)`. Rising edge of `usb_rxact & sel` clears 10-bit `rx_cnt`. Each `usb_rxval & sel` increments it. `usb_rxpktval & sel` pushes `rx_cnt` into the length FIFO, excluding any `usb_rxval` in the same cycle. Packets that end without a commit push nothing.
- Zero-count commits are not pushed. Maximum packet size is 512; `rx_cnt` saturates at 1023.
- Push while full: entry dropped, `len_overflow` set until reset.
- Dispatcher FSM has two states, IDLE and FWD.
- IDLE: when the length FIFO is non-empty and `s_axis_tvalid=1`:
  - pop the FIFO;
  - load `rem` with the length;
  - latch `port = 1` if `s_axis_tdata` is 0x05 (DAP_Transfer) or 0x06 (DAP_TransferBlock), otherwise `port = 0`;
  - go to FWD.
  - No byte is consumed in IDLE, so the command byte is the first byte forwarded.
- FWD: pass-through to `m{port}`: `tdata = s_axis_tdata`, `tvalid = s_axis_tvalid`, `s_axis_tready = m{port}_axis_tready`. The unselected port holds `tvalid=0`.
- `tlast = (rem == 1)`. `rem` decrements on each handshake. The handshake with `rem==1` returns the FSM to IDLE.
- `s_axis_tready=0` in IDLE.

## Timing
- Reset values: all `m*_tvalid/tlast` 0, `m*_tdata` 0, `s_axis_tready` 0, `len_full` 0, `len_overflow` 0, `transfer_abort` 0, FSM IDLE, length FIFO empty.
- IDLE→FWD takes 1 cycle after both conditions are true. FWD is zero-latency combinational pass-through.
- The next packet can start 1 cycle after the last-byte handshake, because IDLE is always visited between packets.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged, and this holds even when the FIFO is full.
- `len_full` is combinational from occupancy == `P_LEN_DEPTH`.
- Mid-operation reset returns everything to its reset values immediately. Any partial packet in the receive FIFO is not re-aligned, so reset must be applied together with the receive FIFO.

## Configuration
- `DAP_RX_ABORT_EN` defined: the monitor flags the first `usb_rxval & sel` byte of each packet. If that byte is 0x07 (DAP_TransferAbort), `transfer_abort` pulses high for 1 cycle on the next clock. This happens at USB reception time, ahead of queued packets. The packet is still queued and dispatched to port 0.
- Undefined: `transfer_abort` is tied to 0 and the first-byte detection logic is absent.

## Test plan
- Single 3-byte packet {0x00,0x01,0x02}, sinks always ready → m0 receives 3 beats, `tlast` on 0x02, m1 idle.
- Packet {0x06,0xAA,0xBB,0xCC,0xDD} → all 5 beats on m1, `tlast` on 0xDD; m0_tvalid stays 0.
- Back-to-back packets of 2 and 4 bytes with m0_tready toggling every cycle → exactly 2 and 4 beats forwarded, one IDLE cycle between packets, no data loss.
- 9 committed packets, depth 8, no draining → `len_full` rises after the 8th commit. The 9th commit sets `len_overflow`. After draining, 8 packets are forwarded with correct lengths.
- Packet aborted (`usb_rxact` drops with no `usb_rxpktval`), then a 2-byte committed packet → only one length pushed, value 2.
- With `DAP_RX_ABORT_EN`: packet {0x07} received while m1 is stalled mid-packet → `transfer_abort` pulses 1 cycle after the 0x07 `usb_rxval`. The 0x07 packet is later forwarded on m0 with `tlast`.
